// File: rtl/btn_debounce_sync.sv
// btn_debounce_sync: two-channel push-button / switch conditioner.
// Each channel runs its raw asynchronous level through a 2-FF synchroniser.
// A stability counter then rejects contact bounce. The channel presents a clean
// registered level together with one-cycle rise and fall pulses.
// btn_clean[1:0] drives the a/b inputs of the downstream 2-input gate stage.
module btn_debounce_sync #(
    // Consecutive stable synchronised cycles needed to accept a change.
    parameter int unsigned STABLE_CYCLES = 1_000_000,
    // Width of each per-channel stability counter; must hold STABLE_CYCLES-1.
    parameter int unsigned CNT_W         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_raw,
    output logic [1:0] btn_clean,
    output logic [1:0] btn_rise,
    output logic [1:0] btn_fall
);

    localparam int unsigned NumCh = 2;

    // Terminal count: the WAIT state has seen STABLE_CYCLES samples after the entry sample.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    // LOW/HIGH are settled levels; WAIT_* are qualifying a candidate change.
    typedef enum logic [1:0] {
        StLow,
        StWaitHi,
        StHigh,
        StWaitLo
    } state_e;

    // ------------------------------------------------------------------
    // Synchroniser: meta_q is the metastability catch stage.
    // sync_q is btn_raw delayed by two rising edges. No logic sits on the raw input.
    // ------------------------------------------------------------------
    logic [NumCh-1:0] meta_q;
    logic [NumCh-1:0] sync_q;

    // Two-flop synchroniser chain for both channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_raw;
            sync_q <= meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce FSM. The channels share only clk and rst.
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < NumCh; ch++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             clean_q, clean_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;
        logic             smp;
        logic             cnt_done;

        assign smp      = sync_q[ch];
        assign cnt_done = (cnt_q == CntLast);

        // Next-state, counter and output decode for one channel.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            clean_d = clean_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;

            unique case (state_q)
                StLow: begin
                    clean_d = 1'b0;
                    if (smp) begin
                        state_d = StWaitHi;
                        cnt_d   = '0;
                    end
                end

                StWaitHi: begin
                    clean_d = 1'b0;
                    if (!smp) begin
                        // A low sample mid-qualification counts as bounce.
                        // Fall back to LOW and restart the count.
                        state_d = StLow;
                        cnt_d   = '0;
                    end else if (cnt_done) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                        clean_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                StHigh: begin
                    clean_d = 1'b1;
                    if (!smp) begin
                        state_d = StWaitLo;
                        cnt_d   = '0;
                    end
                end

                StWaitLo: begin
                    clean_d = 1'b1;
                    if (smp) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end else if (cnt_done) begin
                        state_d = StLow;
                        cnt_d   = '0;
                        clean_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = StLow;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                end
            endcase
        end

        // State, counter and registered outputs for one channel.
        // An asynchronous reset aborts any count in progress.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= StLow;
                cnt_q   <= '0;
                clean_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                clean_q <= clean_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign btn_clean[ch] = clean_q;
        assign btn_rise[ch]  = rise_q;
        assign btn_fall[ch]  = fall_q;
    end

endmodule
